// File: rtl/mmu_bus_arbiter_pkg.sv
// Shared types for the MMU port arbiter: cbus request/response records,
// arbiter FSM states and requester identifiers.
package mmu_bus_arbiter_pkg;

    typedef struct packed {
        logic        valid;
        logic        write;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_GRANT,
        ARB_RELEASE
    } arb_state_t;

    localparam logic OWNER_I = 1'b0;
    localparam logic OWNER_D = 1'b1;

    // A walk is complete only on the final, accepted beat.
    function automatic logic resp_done(input cbus_resp_t r);
        return r.last & r.ready;
    endfunction

endpackage

// File: rtl/mmu_bus_watchdog.sv
// Grant-duration watchdog: saturating cycle counter cleared on each new grant,
// with a sticky error flag that only reset clears.
module mmu_bus_watchdog
    import mmu_bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 4095
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic active,
    output logic timeout_err
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] cnt_next;
    logic [CW-1:0] cnt_inc;
    logic          timeout_reg;
    logic          timeout_next;

    always_comb begin
        cnt_inc = (cnt_reg == {CW{1'b1}}) ? cnt_reg : cnt_reg + CW'(1);
    end

    always_comb begin
        cnt_next     = cnt_reg;
        timeout_next = timeout_reg;
        if (start) begin
            cnt_next = '0;
        end else if (active) begin
            cnt_next = cnt_inc;
            // The flag rises at the end of the TIMEOUT-th grant cycle.
            if ((TIMEOUT != 0) && (cnt_inc == CW'(TIMEOUT))) begin
                timeout_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg     <= '0;
            timeout_reg <= 1'b0;
        end else begin
            cnt_reg     <= cnt_next;
            timeout_reg <= timeout_next;
        end
    end

    assign timeout_err = timeout_reg;

endmodule

// File: rtl/mmu_bus_arbiter.sv
// Two-master arbiter in front of the MMU port: grants fetch or data access one
// walk at a time, holds the latched request stable and routes completion back.
module mmu_bus_arbiter
    import mmu_bus_arbiter_pkg::*;
#(
    parameter int RR_EN   = 1,
    parameter int TIMEOUT = 4095
) (
    input  logic       clk,
    input  logic       rst,
    input  cbus_req_t  ireq,
    output cbus_resp_t iresp,
    output logic       iexc,
    input  cbus_req_t  dreq,
    output cbus_resp_t dresp,
    output logic       dexc,
    output cbus_req_t  mreq,
    input  cbus_resp_t mresp,
    input  logic       mmu_exc,
    output logic       owner,
    output logic       busy,
    output logic       timeout_err
);

    arb_state_t state_reg, state_next;
    cbus_req_t  req_reg, req_next;
    logic       owner_reg, owner_next;
    logic       rr_ptr_reg, rr_ptr_next;
    logic       abort_reg, abort_next;

    logic       in_grant;
    logic       any_valid;
    logic       both_valid;
    logic       winner;
    logic       grant_start;
    logic       route_resp;
    logic       route_exc;
    logic [1:0] valid_vec;
    logic [1:0] exc_vec;
    cbus_resp_t resp_vec [2];

    function automatic logic pick_winner(input logic iv, input logic dv, input logic rr);
        if (iv && dv) begin
            return (RR_EN != 0) ? rr : OWNER_D;
        end else if (dv) begin
            return OWNER_D;
        end
        return OWNER_I;
    endfunction

    assign valid_vec   = {dreq.valid, ireq.valid};
    assign any_valid   = ireq.valid | dreq.valid;
    assign both_valid  = ireq.valid & dreq.valid;
    assign winner      = pick_winner(ireq.valid, dreq.valid, rr_ptr_reg);
    assign in_grant    = (state_reg == ARB_GRANT);
    assign grant_start = (state_reg == ARB_IDLE) && any_valid;

    always_comb begin
        state_next  = state_reg;
        req_next    = req_reg;
        owner_next  = owner_reg;
        rr_ptr_next = rr_ptr_reg;
        abort_next  = abort_reg;
        case (state_reg)
            ARB_IDLE: begin
                if (any_valid) begin
                    req_next   = (winner == OWNER_D) ? dreq : ireq;
                    owner_next = winner;
                    abort_next = 1'b0;
                    if ((RR_EN != 0) && both_valid) begin
                        rr_ptr_next = ~winner;
                    end
                    state_next = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                // Owner gave up mid-walk; finish the walk but drop its result.
                if (!valid_vec[owner_reg]) begin
                    abort_next = 1'b1;
                end
                if (mmu_exc || resp_done(mresp)) begin
                    state_next = ARB_RELEASE;
                end
            end
            ARB_RELEASE: begin
                state_next = ARB_IDLE;
            end
            default: begin
                state_next = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= ARB_IDLE;
            req_reg    <= '0;
            owner_reg  <= OWNER_I;
            rr_ptr_reg <= OWNER_I;
            abort_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            req_reg    <= req_next;
            owner_reg  <= owner_next;
            rr_ptr_reg <= rr_ptr_next;
            abort_reg  <= abort_next;
        end
    end

    always_comb begin
        mreq = '0;
        if (in_grant) begin
            mreq       = req_reg;
            mreq.valid = 1'b1;
        end
    end

    // Exception takes precedence over a completing beat in the same cycle.
    assign route_exc  = in_grant && mmu_exc && !abort_reg;
    assign route_resp = in_grant && !mmu_exc && resp_done(mresp) && !abort_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_route
            assign resp_vec[gi] = (route_resp && (owner_reg == 1'(gi))) ? mresp : '0;
            assign exc_vec[gi]  = route_exc && (owner_reg == 1'(gi));
        end
    endgenerate

    assign iresp = resp_vec[OWNER_I];
    assign dresp = resp_vec[OWNER_D];
    assign iexc  = exc_vec[OWNER_I];
    assign dexc  = exc_vec[OWNER_D];
    assign owner = owner_reg;
    assign busy  = (state_reg != ARB_IDLE);

    mmu_bus_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk         (clk),
        .rst         (rst),
        .start       (grant_start),
        .active      (in_grant),
        .timeout_err (timeout_err)
    );

endmodule

// File: tb/tb_mmu_bus_arbiter.sv
// Directed bench: round-robin instance with an 8-cycle watchdog, plus a
// fixed-priority instance with the watchdog disabled sharing the same stimulus.
module tb_mmu_bus_arbiter;
    import mmu_bus_arbiter_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    cbus_req_t  ireq, dreq, mreq, mreq_fp;
    cbus_resp_t iresp, dresp, mresp, iresp_fp, dresp_fp;
    logic       iexc, dexc, mmu_exc, owner, busy, timeout_err;
    logic       iexc_fp, dexc_fp, owner_fp, busy_fp, timeout_err_fp;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mmu_bus_arbiter #(.RR_EN(1), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .ireq(ireq), .iresp(iresp), .iexc(iexc),
        .dreq(dreq), .dresp(dresp), .dexc(dexc),
        .mreq(mreq), .mresp(mresp), .mmu_exc(mmu_exc),
        .owner(owner), .busy(busy), .timeout_err(timeout_err)
    );

    mmu_bus_arbiter #(.RR_EN(0), .TIMEOUT(0)) dut_fp (
        .clk(clk), .rst(rst),
        .ireq(ireq), .iresp(iresp_fp), .iexc(iexc_fp),
        .dreq(dreq), .dresp(dresp_fp), .dexc(dexc_fp),
        .mreq(mreq_fp), .mresp(mresp), .mmu_exc(mmu_exc),
        .owner(owner_fp), .busy(busy_fp), .timeout_err(timeout_err_fp)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_grant(input string tag);
        int k = 0;
        while (!mreq.valid && k < 20) begin
            cyc();
            k++;
        end
        chk({tag, "_grant"}, mreq.valid, 1'b1);
    endtask

    // Waits for the grant, checks owner/address, completes the walk with data.
    task automatic respond(input string tag, input logic exp_owner,
                           input logic [31:0] exp_addr, input logic [31:0] data);
        wait_grant(tag);
        chk({tag, "_owner"}, owner, exp_owner);
        chk({tag, "_maddr"}, mreq.addr, exp_addr);
        mresp = '{ready: 1'b1, last: 1'b1, data: data};
        #1;
        if (exp_owner == OWNER_D) begin
            chk({tag, "_dresp"}, dresp, {2'b11, data});
            chk({tag, "_iresp0"}, iresp, 0);
        end else begin
            chk({tag, "_iresp"}, iresp, {2'b11, data});
            chk({tag, "_dresp0"}, dresp, 0);
        end
        $display("txn %s: owner=%0d addr=%h data=%h", tag, owner, mreq.addr, data);
        cyc();
        mresp = '0;
        #1;
        chk({tag, "_release"}, mreq, 0);
    endtask

    initial begin
        rst = 1'b1;
        ireq = '0;
        dreq = '0;
        mresp = '0;
        mmu_exc = 1'b0;

        // Reset state
        cyc();
        chk("rst_mreq", mreq, 0);
        chk("rst_resp", {iresp, dresp}, 0);
        chk("rst_flags", {iexc, dexc, owner, busy, timeout_err}, 0);
        cyc();
        rst = 1'b0;
        #1;

        // 1: lone data request, 1-cycle grant latency, same-cycle response
        cyc();
        dreq = '{valid: 1'b1, write: 1'b0, be: 4'hF, addr: 32'h8000_1000, wdata: 32'h0};
        #1;
        chk("t1_latency", mreq.valid, 1'b0);
        respond("t1", OWNER_D, 32'h8000_1000, 32'h0000_DEAD);
        dreq = '0;
        cyc();
        chk("t1_idle", busy, 1'b0);

        // 2: both held -> I,D,I,D with round robin; fixed priority picks D
        ireq = '{valid: 1'b1, write: 1'b0, be: 4'hF, addr: 32'h0000_1100, wdata: 32'h0};
        dreq = '{valid: 1'b1, write: 1'b1, be: 4'h3, addr: 32'h8000_2200, wdata: 32'h55AA};
        wait_grant("t2_fp");
        chk("t2_fp_owner", owner_fp, OWNER_D);
        respond("t2_a", OWNER_I, 32'h0000_1100, 32'h0000_0A01);
        respond("t2_b", OWNER_D, 32'h8000_2200, 32'h0000_0B02);
        respond("t2_c", OWNER_I, 32'h0000_1100, 32'h0000_0A03);
        respond("t2_d", OWNER_D, 32'h8000_2200, 32'h0000_0B04);
        ireq = '0;
        dreq = '0;
        cyc();

        // 3: MMU fault during a data walk wins over a completing beat
        dreq = '{valid: 1'b1, write: 1'b0, be: 4'hF, addr: 32'h8000_3000, wdata: 32'h0};
        wait_grant("t3");
        chk("t3_noexc", dexc, 1'b0);
        cyc();
        mmu_exc = 1'b1;
        mresp = '{ready: 1'b1, last: 1'b1, data: 32'h1111};
        #1;
        chk("t3_dexc", dexc, 1'b1);
        chk("t3_dresp", dresp.ready, 1'b0);
        chk("t3_iexc", iexc, 1'b0);
        $display("txn t3: owner=%0d fault addr=%h", owner, mreq.addr);
        cyc();
        mmu_exc = 1'b0;
        mresp = '0;
        dreq = '0;
        #1;
        chk("t3_pulse", dexc, 1'b0);
        chk("t3_rel", {busy, mreq.valid}, 2'b10);
        cyc();
        chk("t3_idle", busy, 1'b0);

        // 4: fetch flushed mid-walk; walk completes on latched address, result dropped
        ireq = '{valid: 1'b1, write: 1'b0, be: 4'hF, addr: 32'h0000_4000, wdata: 32'h0};
        wait_grant("t4");
        chk("t4_owner", owner, OWNER_I);
        cyc();
        ireq = '{valid: 1'b0, write: 1'b0, be: 4'h0, addr: 32'hFFFF_0000, wdata: 32'h0};
        #1;
        chk("t4_hold", {mreq.valid, mreq.addr}, {1'b1, 32'h0000_4000});
        cyc();
        mresp = '{ready: 1'b1, last: 1'b1, data: 32'hBEEF};
        #1;
        chk("t4_supp", iresp, 0);
        chk("t4_addr", mreq.addr, 32'h0000_4000);
        $display("txn t4: owner=%0d aborted addr=%h", owner, mreq.addr);
        cyc();
        mresp = '0;
        ireq = '0;
        dreq = '{valid: 1'b1, write: 1'b0, be: 4'hF, addr: 32'h8000_4400, wdata: 32'h0};
        #1;
        respond("t4_d", OWNER_D, 32'h8000_4400, 32'h0000_1234);
        dreq = '0;
        cyc();

        // 5: reset mid-grant after a tie moved the pointer to D
        ireq = '{valid: 1'b1, write: 1'b0, be: 4'hF, addr: 32'h0000_5000, wdata: 32'h0};
        dreq = '{valid: 1'b1, write: 1'b0, be: 4'hF, addr: 32'h8000_5000, wdata: 32'h0};
        wait_grant("t5");
        chk("t5_owner", owner, OWNER_I);
        cyc();
        rst = 1'b1;
        #1;
        chk("t5_rst", {busy, mreq.valid, owner}, 3'b000);
        cyc();
        rst = 1'b0;
        #1;
        respond("t5_tie", OWNER_I, 32'h0000_5000, 32'h0000_5555);
        ireq = '0;
        dreq = '0;
        cyc();

        // 6: MMU never answers -> watchdog after 8 grant cycles, sticky until reset
        dreq = '{valid: 1'b1, write: 1'b0, be: 4'hF, addr: 32'h8000_6000, wdata: 32'h0};
        wait_grant("t6");
        chk("t6_c1", timeout_err, 1'b0);
        repeat (7) cyc();
        chk("t6_c8", timeout_err, 1'b0);
        cyc();
        chk("t6_c9", timeout_err, 1'b1);
        chk("t6_busy", busy, 1'b1);
        chk("t6_fp_off", timeout_err_fp, 1'b0);
        respond("t6_end", OWNER_D, 32'h8000_6000, 32'h0000_6666);
        dreq = '0;
        cyc();
        cyc();
        chk("t6_sticky", {busy, timeout_err}, 2'b01);
        rst = 1'b1;
        #1;
        chk("t6_clear", timeout_err, 1'b0);
        cyc();
        rst = 1'b0;
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
